// File: rtl/dist_pkg.sv
// dist_pkg: shared FSM state type, BRAM flag bit positions and address-width helper
package dist_pkg;
  typedef enum logic [2:0] {IDLE, LDQ, LDR, PIPE, ACC, SQRT, OUT, FIN} state_e;
  localparam int FLAG_CS  = 3;
  localparam int FLAG_WE  = 2;
  localparam int FLAG_OE  = 1;
  localparam int FLAG_SEL = 0;
  function automatic int addr_w(input int numvec, input int vecwidth);
    return $clog2((numvec + 1) * vecwidth);
  endfunction
endpackage

// File: rtl/dist_vec_buf.sv
// dist_vec_buf: VECWIDTH x VARWIDTH register file with indexed write, flat read bus, async clear
module dist_vec_buf #(
  parameter int VARWIDTH = 32,
  parameter int VECWIDTH = 10,
  parameter int EW       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [EW-1:0]                idx_i,
  input  logic [VARWIDTH-1:0]          wdata_i,
  output logic [VARWIDTH*VECWIDTH-1:0] vec_o
);
  logic [VARWIDTH*VECWIDTH-1:0] vec_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vec_q <= '0;
    else if (we_i) vec_q[idx_i*VARWIDTH +: VARWIDTH] <= wdata_i;
  assign vec_o = vec_q;
endmodule

// File: rtl/dist_seq_ctrl.sv
// dist_seq_ctrl: sequencer loading query/reference vectors and stepping the distance datapath.
// Define DIST_ARGMIN_EN to add running minimum-distance tracking (MIN_Dist / MIN_Idx).
module dist_seq_ctrl
  import dist_pkg::*;
#(
  parameter int VARWIDTH = 32,
  parameter int VECWIDTH = 10,
  parameter int NUMVEC   = 16,
  parameter int AW       = addr_w(NUMVEC, VECWIDTH),
  localparam int IW      = (NUMVEC > 1) ? $clog2(NUMVEC) : 1
) (
  input  logic                         clk,
  input  logic                         RST_N,
  input  logic                         STARTCALC,
  input  logic [VARWIDTH-1:0]          RD_Data,
  output logic [AW-1:0]                ADDR_Bram,
  output logic [3:0]                   FLAG_Bram,
  output logic [VARWIDTH*VECWIDTH-1:0] invec0,
  output logic [VARWIDTH*VECWIDTH-1:0] invec1,
  output logic                         EN_Pipe,
  output logic                         EN_Acc,
  output logic                         EN_Sqrt,
  output logic                         RST_Acc,
  output logic                         RST_Sqrt,
  output logic                         PRE_Acc,
  input  logic                         RDY_Pipe,
  input  logic                         RDY_Acc,
  input  logic                         RDY_Sqrt,
  input  logic [VARWIDTH-1:0]          SQRT_Val,
  output logic [VARWIDTH-1:0]          DIST_Out,
  output logic [IW-1:0]                DIST_Idx,
  output logic                         DIST_Valid,
  input  logic                         DIST_Ready,
  output logic                         BUSY,
`ifdef DIST_ARGMIN_EN
  output logic [VARWIDTH-1:0]          MIN_Dist,
  output logic [IW-1:0]                MIN_Idx,
`endif
  output logic                         DONE
);
  localparam int EW = (VECWIDTH > 1) ? $clog2(VECWIDTH) : 1;
  localparam int CW = $clog2(VECWIDTH + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic [IW-1:0] k_q, idx_q;
  logic [VARWIDTH-1:0] dist_q;
  logic en_pipe_q, en_pipe_d, en_acc_q, en_acc_d, en_sqrt_q, en_sqrt_d;
  logic rst_stg_q, rst_stg_d, pre_acc_q, pre_acc_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic start, load, issue, cap, ld_end, last_k, sqrt_hit, accept;
  logic [EW-1:0] wr_idx;
  assign start    = (state_q == IDLE) && STARTCALC;
  assign load     = (state_q == LDQ) || (state_q == LDR);
  assign ld_end   = cnt_q == CW'(VECWIDTH);
  assign issue    = load && !ld_end;
  // read data lags its address by one cycle, so the capture slot trails the issue slot
  assign cap      = load && (cnt_q != '0);
  assign wr_idx   = EW'(cnt_q - 1'b1);
  assign last_k   = k_q == IW'(NUMVEC - 1);
  assign sqrt_hit = (state_q == SQRT) && RDY_Sqrt;
  assign accept   = (state_q == OUT) && DIST_Ready;
  assign cnt_d    = issue ? cnt_q + 1'b1 : (load && !ld_end ? cnt_q : '0);
  always_ff @(posedge clk or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (STARTCALC) state_d = LDQ;
      LDQ:     if (ld_end) state_d = LDR;
      LDR:     if (ld_end) state_d = PIPE;
      PIPE:    if (RDY_Pipe) state_d = ACC;
      ACC:     if (RDY_Acc) state_d = SQRT;
      SQRT:    if (RDY_Sqrt) state_d = OUT;
      OUT:     if (DIST_Ready) state_d = last_k ? FIN : LDR;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    en_pipe_d = state_d == PIPE;
    en_acc_d  = state_d == ACC;
    en_sqrt_d = state_d == SQRT;
    rst_stg_d = (state_d == PIPE) && (state_q != PIPE);
    pre_acc_d = (state_d == ACC) && (state_q != ACC);
    valid_d   = state_d == OUT;
    busy_d    = state_d != IDLE;
    done_d    = state_d == FIN;
  end
  always_ff @(posedge clk or negedge RST_N)
    if (!RST_N) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      dist_q    <= '0;
      en_pipe_q <= 1'b0;
      en_acc_q  <= 1'b0;
      en_sqrt_q <= 1'b0;
      rst_stg_q <= 1'b0;
      pre_acc_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      en_pipe_q <= en_pipe_d;
      en_acc_q  <= en_acc_d;
      en_sqrt_q <= en_sqrt_d;
      rst_stg_q <= rst_stg_d;
      pre_acc_q <= pre_acc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      // query and references are contiguous in BRAM, so one running address covers them all
      if (start) addr_q <= '0;
      else if (issue) addr_q <= addr_q + 1'b1;
      if (start) k_q <= '0;
      else if (accept && !last_k) k_q <= k_q + 1'b1;
      if (sqrt_hit) begin
        dist_q <= SQRT_Val;
        idx_q  <= k_q;
      end
    end
  always_comb begin
    FLAG_Bram           = '0;
    FLAG_Bram[FLAG_CS]  = issue;
    FLAG_Bram[FLAG_WE]  = 1'b0;
    FLAG_Bram[FLAG_OE]  = issue;
    FLAG_Bram[FLAG_SEL] = state_q == LDQ;
  end
  assign ADDR_Bram  = issue ? addr_q : '0;
  assign EN_Pipe    = en_pipe_q;
  assign EN_Acc     = en_acc_q;
  assign EN_Sqrt    = en_sqrt_q;
  assign RST_Acc    = rst_stg_q;
  assign RST_Sqrt   = rst_stg_q;
  assign PRE_Acc    = pre_acc_q;
  assign DIST_Out   = dist_q;
  assign DIST_Idx   = idx_q;
  assign DIST_Valid = valid_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  dist_vec_buf #(.VARWIDTH(VARWIDTH), .VECWIDTH(VECWIDTH), .EW(EW)) u_qbuf (
    .clk(clk), .rst_n(RST_N), .we_i(cap && (state_q == LDQ)), .idx_i(wr_idx),
    .wdata_i(RD_Data), .vec_o(invec0)
  );
  dist_vec_buf #(.VARWIDTH(VARWIDTH), .VECWIDTH(VECWIDTH), .EW(EW)) u_rbuf (
    .clk(clk), .rst_n(RST_N), .we_i(cap && (state_q == LDR)), .idx_i(wr_idx),
    .wdata_i(RD_Data), .vec_o(invec1)
  );
`ifdef DIST_ARGMIN_EN
  logic [VARWIDTH-1:0] min_q;
  logic [IW-1:0] min_idx_q;
  always_ff @(posedge clk or negedge RST_N)
    if (!RST_N) begin
      min_q     <= '0;
      min_idx_q <= '0;
    end else if (start) begin
      min_q     <= '1;
      min_idx_q <= '0;
    end else if (sqrt_hit && (SQRT_Val < min_q)) begin
      min_q     <= SQRT_Val;
      min_idx_q <= k_q;
    end
  assign MIN_Dist = min_q;
  assign MIN_Idx  = min_idx_q;
`endif
endmodule

// File: tb/tb_dist_seq_ctrl.sv
// tb_dist_seq_ctrl: directed bench with a BRAM model and an exact Euclidean datapath model
module tb_dist_seq_ctrl;
  logic clk = 1'b0;
  logic RST_N, STARTCALC, RDY_Pipe, RDY_Acc, RDY_Sqrt, DIST_Ready;
  logic [31:0] RD_Data = '0;
  logic [3:0] ADDR_Bram, FLAG_Bram;
  logic [127:0] invec0, invec1;
  logic EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc;
  logic [31:0] SQRT_Val, DIST_Out;
  logic DIST_Idx, DIST_Valid, BUSY, DONE;
  int errors = 0, checks = 0, rd_cnt = 0, rd_base, n;
  logic [31:0] mem [0:15] = '{1, 2, 3, 4, 1, 2, 3, 4, 4, 6, 3, 4, 0, 0, 0, 0};

  always #5 clk = ~clk;

  function automatic logic [31:0] dist4(input logic [127:0] a, input logic [127:0] b);
    int s, d, r;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(a[i*32 +: 32]) - int'(b[i*32 +: 32]);
      s += d * d;
    end
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return 32'(r);
  endfunction

  assign SQRT_Val = dist4(invec0, invec1);

  always @(posedge clk) if (FLAG_Bram[3]) begin
    RD_Data <= mem[ADDR_Bram];
    rd_cnt  <= rd_cnt + 1;
  end

`ifdef DIST_ARGMIN_EN
  logic [31:0] min_a;
  logic min_a_idx;
  logic m_start;
  logic [31:0] m_rd = '0;
  logic [3:0] m_addr, m_flag;
  logic [127:0] m_iv0, m_iv1;
  logic m_enp, m_ena, m_ens, m_rsta, m_rsts, m_pre, m_valid, m_busy, m_done;
  logic [31:0] m_sqrt, m_dout, m_min;
  logic [1:0] m_didx, m_min_idx;
  logic [31:0] m_mem [0:15] = '{1, 2, 3, 4, 10, 2, 3, 4, 5, 2, 3, 4, 1, 6, 3, 4};
  assign m_sqrt = dist4(m_iv0, m_iv1);
  always @(posedge clk) if (m_flag[3]) m_rd <= m_mem[m_addr];
  dist_seq_ctrl #(.VARWIDTH(32), .VECWIDTH(4), .NUMVEC(3)) u_min (
    .clk(clk), .RST_N(RST_N), .STARTCALC(m_start), .RD_Data(m_rd), .ADDR_Bram(m_addr),
    .FLAG_Bram(m_flag), .invec0(m_iv0), .invec1(m_iv1), .EN_Pipe(m_enp), .EN_Acc(m_ena),
    .EN_Sqrt(m_ens), .RST_Acc(m_rsta), .RST_Sqrt(m_rsts), .PRE_Acc(m_pre), .RDY_Pipe(1'b1),
    .RDY_Acc(1'b1), .RDY_Sqrt(1'b1), .SQRT_Val(m_sqrt), .DIST_Out(m_dout), .DIST_Idx(m_didx),
    .DIST_Valid(m_valid), .DIST_Ready(1'b1), .BUSY(m_busy), .MIN_Dist(m_min),
    .MIN_Idx(m_min_idx), .DONE(m_done)
  );
`endif

  dist_seq_ctrl #(.VARWIDTH(32), .VECWIDTH(4), .NUMVEC(2)) dut (
    .clk(clk), .RST_N(RST_N), .STARTCALC(STARTCALC), .RD_Data(RD_Data), .ADDR_Bram(ADDR_Bram),
    .FLAG_Bram(FLAG_Bram), .invec0(invec0), .invec1(invec1), .EN_Pipe(EN_Pipe), .EN_Acc(EN_Acc),
    .EN_Sqrt(EN_Sqrt), .RST_Acc(RST_Acc), .RST_Sqrt(RST_Sqrt), .PRE_Acc(PRE_Acc),
    .RDY_Pipe(RDY_Pipe), .RDY_Acc(RDY_Acc), .RDY_Sqrt(RDY_Sqrt), .SQRT_Val(SQRT_Val),
    .DIST_Out(DIST_Out), .DIST_Idx(DIST_Idx), .DIST_Valid(DIST_Valid), .DIST_Ready(DIST_Ready),
    .BUSY(BUSY),
`ifdef DIST_ARGMIN_EN
    .MIN_Dist(min_a), .MIN_Idx(min_a_idx),
`endif
    .DONE(DONE)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    STARTCALC = 1'b1;
    @(negedge clk);
    STARTCALC = 1'b0;
  endtask

  initial begin
`ifdef DIST_ARGMIN_EN
    m_start = 1'b0;
`endif
    RST_N = 1'b0; STARTCALC = 1'b0; DIST_Ready = 1'b0;
    RDY_Pipe = 1'b1; RDY_Acc = 1'b1; RDY_Sqrt = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", BUSY, 0);
    check("rst_flag", FLAG_Bram, 0);
    check("rst_valid", DIST_Valid, 0);
    check("rst_buf", invec0, 0);
    check("rst_dist", DIST_Out, 0);
    RST_N = 1'b1;
    @(negedge clk);
    // run 1: result 0 held unaccepted for 7 cycles, stray start while waiting
    rd_base = rd_cnt;
    pulse_start();
    check("ldq_flag", FLAG_Bram, 4'b1011);
    check("ldq_addr", ADDR_Bram, 0);
    check("ldq_busy", BUSY, 1);
    n = 1;
    while (!DIST_Valid && n < 100) begin @(negedge clk); n++; end
    check("lat_first", n, 14);
    check("q_buf", invec0, {32'd4, 32'd3, 32'd2, 32'd1});
    check("r0_buf", invec1, {32'd4, 32'd3, 32'd2, 32'd1});
    check("d0_out", DIST_Out, 0);
    check("d0_idx", DIST_Idx, 0);
    check("rd_first", rd_cnt - rd_base, 8);
    for (int i = 0; i < 7; i++) begin
      check("hold_valid", DIST_Valid, 1);
      check("hold_out", DIST_Out, 0);
      check("hold_idx", DIST_Idx, 0);
      check("hold_reads", rd_cnt - rd_base, 8);
      STARTCALC = (i == 3);
      @(negedge clk);
      STARTCALC = 1'b0;
    end
    DIST_Ready = 1'b1;
    @(negedge clk);
    check("drop_valid", DIST_Valid, 0);
    n = 0;
    while (!DIST_Valid && n < 100) begin @(negedge clk); n++; end
    check("lat_second", n, 8);
    check("r1_buf", invec1, {32'd4, 32'd3, 32'd6, 32'd4});
    check("d1_out", DIST_Out, 5);
    check("d1_idx", DIST_Idx, 1);
    @(negedge clk);
    check("done_pulse", DONE, 1);
    check("done_busy", BUSY, 1);
    check("done_valid", DIST_Valid, 0);
    @(negedge clk);
    check("done_drop", DONE, 0);
    check("idle_busy", BUSY, 0);
    check("rd_total", rd_cnt - rd_base, 12);
    n = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); n += int'(DONE); end
    check("done_once", n, 0);
    // run 2: ACC ready withheld for 5 enabled cycles
    RDY_Acc = 1'b0;
    pulse_start();
    n = 0;
    while (!EN_Pipe && n < 100) begin @(negedge clk); n++; end
    check("rst_acc", RST_Acc, 1);
    check("rst_sqrt", RST_Sqrt, 1);
    @(negedge clk);
    check("rst_acc_drop", RST_Acc, 0);
    n = 0;
    while (EN_Acc && n < 20) begin
      n++;
      check("pre_acc", PRE_Acc, n == 1);
      if (n == 6) RDY_Acc = 1'b1;
      @(negedge clk);
    end
    check("en_acc_len", n, 6);
    n = 0;
    while (!DONE && n < 100) begin @(negedge clk); n++; end
    check("done_run2", DONE, 1);
    check("run2_out", DIST_Out, 5);
    // run 3: reset asserted mid reference load
    @(negedge clk);
    pulse_start();
    n = 0;
    while (!(FLAG_Bram[3] && !FLAG_Bram[0]) && n < 100) begin @(negedge clk); n++; end
    check("in_ldr", FLAG_Bram, 4'b1010);
    repeat (2) @(negedge clk);
    RST_N = 1'b0;
    #1;
    check("mr_busy", BUSY, 0);
    check("mr_flag", FLAG_Bram, 0);
    check("mr_addr", ADDR_Bram, 0);
    check("mr_q", invec0, 0);
    check("mr_r", invec1, 0);
    check("mr_dist", DIST_Out, 0);
    check("mr_en", {EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, PRE_Acc, DIST_Valid, DONE}, 0);
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    pulse_start();
    check("re_addr", ADDR_Bram, 0);
    check("re_flag", FLAG_Bram, 4'b1011);
    n = 1;
    while (!DIST_Valid && n < 100) begin @(negedge clk); n++; end
    check("re_lat", n, 14);
    check("re_qbuf", invec0, {32'd4, 32'd3, 32'd2, 32'd1});
    @(negedge clk);
    n = 0;
    while (!DIST_Valid && n < 100) begin @(negedge clk); n++; end
    check("re_d1", DIST_Out, 5);
    n = 0;
    while (!DONE && n < 100) begin @(negedge clk); n++; end
    check("re_done", DONE, 1);
`ifdef DIST_ARGMIN_EN
    check("main_min", min_a, 0);
    check("main_min_idx", min_a_idx, 0);
    @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    check("min_init", m_min, 32'hFFFF_FFFF);
    check("min_idx_init", m_min_idx, 0);
    n = 0;
    while (!m_done && n < 200) begin @(negedge clk); n++; end
    check("min_done", m_done, 1);
    check("min_dist", m_min, 4);
    check("min_idx", m_min_idx, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dist_seq_ctrl.md
# dist_seq_ctrl

Parametrised sequencer for the Euclidean distance datapath (`distcalc_euclid`). One `STARTCALC` pulse loads a query vector from BRAM once, then streams `NUMVEC` reference vectors through the pipe, accumulate and sqrt stages. Each distance is emitted with its vector index over a valid/ready handshake. It replaces the fixed-size distance control unit, owns the vector buffers, and supports any vector width and any reference count.

## Interface
- `VARWIDTH`, 32, element/result width
- `VECWIDTH`, 10, elements per vector
- `NUMVEC`, 16, reference vectors in BRAM (≥1)
- `AW`, `$clog2((NUMVEC+1)*VECWIDTH)`, BRAM address width (derived)
- `clk`  in  1  clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `STARTCALC`  in  1  start pulse
- `RD_Data`  in  VARWIDTH  BRAM read data, valid one cycle after read issue
- `ADDR_Bram`  out  AW  BRAM word address
- `FLAG_Bram`  out  4  [3]=cs, [2]=we (always 0), [1]=oe, [0]=1 when loading query buffer
- `invec0` / `invec1`  out  VARWIDTH*VECWIDTH  query / reference buffers, element i at [i*VARWIDTH +: VARWIDTH]
- `EN_Pipe`, `EN_Acc`, `EN_Sqrt`  out  1  stage enables
- `RST_Acc`, `RST_Sqrt`, `PRE_Acc`  out  1  stage reset/preload pulses
- `RDY_Pipe`, `RDY_Acc`, `RDY_Sqrt`  in  1  stage ready flags
- `SQRT_Val`  in  VARWIDTH  datapath result
- `DIST_Out`  out  VARWIDTH  registered distance
- `DIST_Idx`  out  $clog2(NUMVEC) (min 1)  reference index
- `DIST_Valid`  out  1; `DIST_Ready`  in  1  result handshake
- `BUSY`  out  1; `DONE`  out  1  one-cycle pulse after last result accepted

## Operation
- Memory map: query at addresses 0..VECWIDTH-1; reference k at (k+1)*VECWIDTH + e.
- States: IDLE → LDQ → LDR → PIPE → ACC → SQRT → OUT → (LDR with k+1 | FIN) → IDLE.
- IDLE: `STARTCALC` captured; k=0. `STARTCALC` outside IDLE is ignored.
- LDQ/LDR: each cycle issue one read (cs=oe=1, address increments); `RD_Data` written to buffer element e one cycle later. `FLAG_Bram[0]`=1 only in LDQ. The state exits after the last element is captured.
- PIPE: first cycle pulses `RST_Acc` and `RST_Sqrt`. `EN_Pipe` is held high until `RDY_Pipe`=1.
- ACC: `EN_Acc` is held until `RDY_Acc`. `PRE_Acc` is high only on the first ACC cycle.
- SQRT: `EN_Sqrt` is held until `RDY_Sqrt`. On that cycle, `SQRT_Val` is latched into `DIST_Out` and k into `DIST_Idx`.
- OUT: `DIST_Valid`=1. `DIST_Out` and `DIST_Idx` are stable until `DIST_Valid`&`DIST_Ready`. If k=NUMVEC-1 go to FIN, else k++ and go to LDR.
- FIN: `DONE`=1 for one cycle, then IDLE.
- `BUSY`=1 in every state except IDLE.
- Reset (any time, including mid-run): state IDLE, all outputs 0, buffers 0, k=0. An in-flight BRAM read is discarded.

## Timing
- `STARTCALC` at cycle 0 → first query read at cycle 1. LDQ takes VECWIDTH+1 cycles; LDR takes VECWIDTH+1 cycles.
- Per vector: (VECWIDTH+1) + pipe + acc + sqrt wait cycles + ≥1 OUT cycle. With all RDY and `DIST_Ready` tied high, each stage takes 1 cycle.
- Enables are registered. A RDY observed at cycle t drops the enable at t+1, and the state advances at t+1.
- `DIST_Valid` never deasserts without acceptance.
- `DONE` is asserted the cycle after the final handshake.

## Configuration
- `DIST_ARGMIN_EN` defined:
  - Adds outputs `MIN_Dist` (VARWIDTH) and `MIN_Idx`.
  - Both are set to all-ones/0 on STARTCALC.
  - Updated at each SQRT latch when `SQRT_Val` < `MIN_Dist` (strict, so on ties the lowest index wins).
  - Both are valid when `DONE` is asserted and held until the next STARTCALC.
- Undefined: ports and logic are absent; all other behaviour is identical.

## Structure
- Package `dist_pkg`:
  - FSM state enum.
  - `FLAG_Bram` bit index constants (CS, WE, OE, SEL).
  - Address-width helper function.
- Sub-module `dist_vec_buf`: VECWIDTH×VARWIDTH register file with write-enable/index port, flattened output bus, and async clear. Instantiated twice (query, reference).

## Test plan
- VECWIDTH=4, NUMVEC=2, query {1,2,3,4}, refs {1,2,3,4},{4,6,3,4}, model datapath, RDY and ready tied high → `DIST_Out`=0 (idx 0), then 5 (idx 1); `DONE` pulses once.
- `DIST_Ready` held low 7 cycles on idx 0 → `DIST_Valid`, `DIST_Out`, `DIST_Idx` stable all 7 cycles; no BRAM reads issued meanwhile.
- `RDY_Acc` delayed 5 cycles → `EN_Acc` high exactly 5 cycles + 1; `PRE_Acc` high only the first cycle.
- `STARTCALC` pulsed mid-run → ignored. `RST_N` low during LDR → all outputs 0 immediately; new start reloads query from address 0.
- `DIST_ARGMIN_EN`, NUMVEC=3, distances 9, 4, 4 → `MIN_Dist`=4, `MIN_Idx`=1 at `DONE`.
